rf_wb_arbiter: RTL and testbench

Shares the single synchronous write port of the RV32I register file among `NUM_REQ` write-back producers (ALU, load unit, multi-cycle mul/div) using round-robin arbitration with a valid/ready handshake. Drives the register file's write enable, address and data from a registered stage. Also keeps a per-register pending-write scoreboard that decode uses to detect RAW hazards. Sits between the execute/memory units and the register file; decode reserves destinations and queries busy status.

---
 rtl/rv32i_pkg.sv | 8 +
 rtl/rf_wb_arbiter_if.sv | 13 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/rf_wb_arbiter.sv | 65 ++++++
 tb/tb_rf_wb_arbiter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths and types for register file, decode and write-back.
package rv32i_pkg;
    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: write-back request bus between producers and the arbiter.
interface rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rv32i_pkg::XLEN,
    parameter int REG_AW  = rv32i_pkg::REG_AW
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*REG_AW-1:0] req_addr;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [NUM_REQ-1:0]        req_ready;
    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; one-hot grant plus index.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    // Scanning from the far end lets the nearest requester after ptr overwrite the rest.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                idx = W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port with a
// pending-write scoreboard for decode's RAW hazard checks.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rv32i_pkg::XLEN,
    parameter int REG_AW  = rv32i_pkg::REG_AW,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    rf_wb_arbiter_if.slave    bus,
    input  logic              rsv_valid,
    input  logic [REG_AW-1:0] rsv_addr,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [GW-1:0]     grant_id
);
    localparam int NR = 1 << REG_AW;
    logic [GW-1:0]     rr_ptr, idx;
    logic [NUM_REQ-1:0] gnt;
    logic [NR-1:0]     busy, clr, set;
    logic [REG_AW-1:0] win_addr;
    logic [XLEN-1:0]   win_data;
    logic              xfer;
    rr_arbiter #(.N(NUM_REQ), .W(GW)) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (idx)
    );
    assign bus.req_ready = reset_n ? gnt : '0;
    assign xfer     = |bus.req_ready;
    assign win_addr = bus.req_addr[int'(idx)*REG_AW +: REG_AW];
    assign win_data = bus.req_data[int'(idx)*XLEN +: XLEN];
    assign clr      = xfer ? NR'(1) << win_addr : '0;
    assign set      = rsv_valid ? NR'(1) << rsv_addr : '0;
    // The output-stage term covers the cycle before the write lands in the register file.
    assign rs1_busy = busy[rs1_addr] | (rf_we && rf_waddr == rs1_addr && rs1_addr != '0);
    assign rs2_busy = busy[rs2_addr] | (rf_we && rf_waddr == rs2_addr && rs2_addr != '0);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            busy     <= '0;
        end else begin
            rf_we <= xfer && win_addr != '0;
            if (xfer) rr_ptr <= idx == GW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
            if (xfer && win_addr != '0) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                grant_id <= idx;
            end
            // Reserve is applied after clear so a same-cycle reserve keeps the register busy.
            busy <= ((busy & ~clr) | set) & ~NR'(1);
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and random checks of rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;
    localparam int N = 3;
    logic clock = 0, reset_n = 0;
    logic rsv_valid;
    logic [4:0] rsv_addr, rs1_addr, rs2_addr, rf_waddr;
    logic rs1_busy, rs2_busy, rf_we;
    logic [31:0] rf_wdata;
    logic [1:0] grant_id;
    logic [31:0] tb_rf [32];
    int checks = 0, errors = 0;
    int m_ptr, m_gid;
    bit m_busy [32];
    bit m_we;
    logic [4:0] m_waddr;
    logic [31:0] m_wdata;

    rf_wb_arbiter_if #(.NUM_REQ(N)) bus ();

    rf_wb_arbiter #(.NUM_REQ(N)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (rf_we) tb_rf[rf_waddr] <= rf_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_gid = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    function automatic logic [4:0] addr_of(int i);
        return bus.req_addr[i*5 +: 5];
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit qbusy(logic [4:0] a);
        return m_busy[a] | (m_we && m_waddr == a && a != 0);
    endfunction

    task automatic set_req(int i, bit v, logic [4:0] a, logic [31:0] d);
        bus.req_valid[i] = v;
        bus.req_addr[i*5 +: 5] = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    task automatic cycle();
        int g;
        logic [4:0] a;
        @(negedge clock);
        g = reset_n ? pick() : -1;
        chk("req_ready", bus.req_ready, g < 0 ? 64'd0 : 64'd1 << g);
        chk("rs1_busy", rs1_busy, reset_n ? qbusy(rs1_addr) : 1'b0);
        chk("rs2_busy", rs2_busy, reset_n ? qbusy(rs2_addr) : 1'b0);
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_waddr", rf_waddr, m_waddr);
            chk("rf_wdata", rf_wdata, m_wdata);
            chk("grant_id", grant_id, m_gid);
        end
        @(posedge clock);
        if (!reset_n) mreset();
        else begin
            m_we = 0;
            if (g >= 0) begin
                a = addr_of(g);
                m_busy[a] = 0;
                m_ptr = (g + 1) % N;
                if (a != 0) begin
                    m_we = 1; m_waddr = a; m_wdata = bus.req_data[g*32 +: 32]; m_gid = g;
                end
            end
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
        end
        #1;
    endtask

    initial begin
        mreset();
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        rsv_valid = 0; rsv_addr = 0; rs1_addr = 3; rs2_addr = 0;
        for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 1), 32'h100 + i);
        #2;
        cycle(); cycle();
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_gid", grant_id, 0);
        reset_n = 1;
        for (int c = 0; c < 6; c++) cycle();
        chk("fair_we", rf_we, 1);
        bus.req_valid = '0;
        set_req(1, 1, 0, 32'hDEADBEEF);
        cycle();
        chk("x0_we", rf_we, 0);
        bus.req_valid = '1;
        cycle();
        chk("ptr2_gid", grant_id, 2);
        bus.req_valid = '0;
        cycle();
        rsv_valid = 1; rsv_addr = 5; rs1_addr = 5;
        cycle();
        rsv_valid = 0;
        chk("sb_busy", rs1_busy, 1);
        set_req(2, 1, 5, 32'h12345678);
        cycle();
        bus.req_valid = '0;
        chk("sb_wecycle_busy", rs1_busy, 1);
        cycle();
        chk("sb_cleared", rs1_busy, 0);
        chk("sb_rfread", tb_rf[5], 32'h12345678);
        rsv_valid = 1; rsv_addr = 7; rs2_addr = 7;
        set_req(0, 1, 7, 32'h77);
        cycle();
        rsv_valid = 0; bus.req_valid = '0;
        cycle(); cycle();
        chk("coll_busy", rs2_busy, 1);
        set_req(0, 1, 7, 32'h78);
        cycle();
        bus.req_valid = '0;
        cycle();
        chk("coll_cleared", rs2_busy, 0);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr = 5'($urandom_range(0, 31));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            cycle();
        end
        rsv_valid = 1; rsv_addr = 9; rs1_addr = 9; rs2_addr = 4;
        for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 4), 32'hA0 + i);
        cycle();
        rsv_valid = 0;
        cycle();
        chk("pre_async_we", rf_we, 1);
        #2 reset_n = 0;
        #1;
        chk("async_we", rf_we, 0);
        chk("async_rs1", rs1_busy, 0);
        chk("async_rs2", rs2_busy, 0);
        chk("async_ready", bus.req_ready, 0);
        mreset();
        cycle();
        reset_n = 1;
        for (int c = 0; c < 4; c++) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
